alu_seq_core: RTL and testbench

Parametrised multi-cycle ALU core with valid/ready handshakes on both sides. It is the successor to the 8-bit combinational ALU: operand width is configurable, a sequential shift-add multiplier is added, status flags are produced, and an accumulator mode chains operations. It sits behind the Tiny Tapeout top-level wrapper, which packs pins into operands and unpacks results.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_mul_seq.sv | 61 ++++++
 rtl/alu_seq_core.sv | 168 ++++++++++++++++
 tb/tb_alu_seq_core.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared encodings for the sequential ALU core
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_SHL = 3'b101,
      OP_SHR = 3'b110,
      OP_MUL = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      MUL  = 2'b01,
      DONE = 2'b10
   } alu_state_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - unsigned shift-add multiplier, one multiplier bit per cycle
module alu_mul_seq
#(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [SHW:0]     cnt;
   logic             busy_q;
   logic [WIDTH:0]   step_sum;
   logic [WIDTH-1:0] hi_nxt;
   logic [WIDTH-1:0] lo_nxt;

   // One shift-add step; product is the value written at this edge, final when done is high
   always_comb begin
      step_sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
      hi_nxt   = step_sum[WIDTH:1];
      lo_nxt   = {step_sum[0], lo[WIDTH-1:1]};
      product  = {hi_nxt, lo_nxt};
      busy     = busy_q;
      done     = busy_q && (cnt == (SHW+1)'(1));
   end

   // Operand load on start, then WIDTH shift-add iterations
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand  <= '0;
         hi     <= '0;
         lo     <= '0;
         cnt    <= '0;
         busy_q <= 1'b0;
      end else if (start) begin
         mcand  <= a;
         hi     <= '0;
         lo     <= b;
         cnt    <= (SHW+1)'(WIDTH);
         busy_q <= 1'b1;
      end else if (busy_q) begin
         hi  <= hi_nxt;
         lo  <= lo_nxt;
         cnt <= cnt - (SHW+1)'(1);
         if (cnt == (SHW+1)'(1)) begin
            busy_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_seq_core.sv
// rtl/alu_seq_core.sv - multi-cycle ALU with accumulator, flags and valid/ready handshakes
module alu_seq_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        op,
   input  logic              use_acc,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  result,
   output logic [WIDTH-1:0]  result_hi,
   output logic [3:0]        flags
);

   localparam int MSB = WIDTH - 1;

   alu_state_e         state;
   alu_state_e         state_nxt;
   alu_op_e            op_e;
   logic               accept;
   logic               mul_start;
   logic               mul_busy;
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_product;

   logic [WIDTH-1:0]   acc;
   logic [WIDTH-1:0]   opa;
   logic [SHW-1:0]     shamt;
   logic [WIDTH:0]     add_full;
   logic [WIDTH:0]     sub_full;
   logic [WIDTH:0]     shl_full;
   logic [WIDTH:0]     shr_full;
   logic [WIDTH-1:0]   alu_res;
   logic [3:0]         alu_flags;
   logic [3:0]         mul_flags;

   alu_mul_seq #(.WIDTH(WIDTH), .SHW(SHW)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (opa),
      .b       (b),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   // Single-cycle ops; carry out of the top bit of the widened shifts is the last bit shifted out
   always_comb begin
      op_e     = alu_op_e'(op);
      opa      = use_acc ? acc : a;
      shamt    = b[SHW-1:0];
      add_full = {1'b0, opa} + {1'b0, b};
      sub_full = {1'b0, opa} - {1'b0, b};
      shl_full = {1'b0, opa} << shamt;
      shr_full = {opa, 1'b0} >> shamt;
      alu_res  = '0;
      alu_flags = '0;
      case (op_e)
         OP_ADD: begin
            alu_res           = add_full[MSB:0];
            alu_flags[FLAG_C] = add_full[WIDTH];
            alu_flags[FLAG_V] = (opa[MSB] == b[MSB]) && (add_full[MSB] != opa[MSB]);
         end
         OP_SUB: begin
            alu_res           = sub_full[MSB:0];
            alu_flags[FLAG_C] = sub_full[WIDTH];
            alu_flags[FLAG_V] = (opa[MSB] != b[MSB]) && (sub_full[MSB] != opa[MSB]);
         end
         OP_AND: alu_res = opa & b;
         OP_OR:  alu_res = opa | b;
         OP_XOR: alu_res = opa ^ b;
         OP_SHL: begin
            alu_res           = shl_full[MSB:0];
            alu_flags[FLAG_C] = shl_full[WIDTH];
         end
         OP_SHR: begin
            alu_res           = shr_full[WIDTH:1];
            alu_flags[FLAG_C] = shr_full[0];
         end
         default: alu_res = '0;
      endcase
      alu_flags[FLAG_N] = alu_res[MSB];
      alu_flags[FLAG_Z] = (alu_res == '0);

      mul_flags         = '0;
      mul_flags[FLAG_N] = mul_product[MSB];
      mul_flags[FLAG_Z] = (mul_product[MSB:0] == '0);
      mul_flags[FLAG_C] = (mul_product[2*WIDTH-1:WIDTH] != '0);
      mul_flags[FLAG_V] = (mul_product[2*WIDTH-1:WIDTH] != '0);
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and handshake outputs, all derived from registered state only
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      mul_start = 1'b0;
      case (state)
         IDLE: begin
            in_ready = !mul_busy;
            if (in_valid && !mul_busy) begin
               accept = 1'b1;
               if (op_e == OP_MUL) begin
                  mul_start = 1'b1;
                  state_nxt = MUL;
               end else begin
                  state_nxt = DONE;
               end
            end
         end
         MUL: begin
            if (mul_done) begin
               state_nxt = DONE;
            end else if (!mul_busy) begin
               state_nxt = IDLE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Result, flags and accumulator load on entry to DONE; held while waiting for out_ready
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc       <= '0;
         result    <= '0;
         result_hi <= '0;
         flags     <= '0;
      end else if (accept && (op_e != OP_MUL)) begin
         acc       <= alu_res;
         result    <= alu_res;
         result_hi <= '0;
         flags     <= alu_flags;
      end else if ((state == MUL) && mul_done) begin
         acc       <= mul_product[MSB:0];
         result    <= mul_product[MSB:0];
         result_hi <= mul_product[2*WIDTH-1:WIDTH];
         flags     <= mul_flags;
      end
   end

endmodule

// File: tb/tb_alu_seq_core.sv
// tb/tb_alu_seq_core.sv - scoreboard bench for alu_seq_core at WIDTH=8
module tb_alu_seq_core;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [2:0]       op = 3'd0;
   logic             use_acc = 1'b0;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] result_hi;
   logic [3:0]       flags;

   typedef struct {
      logic [7:0] res;
      logic [7:0] hi;
      logic [3:0] flg;
      int         lat;
   } exp_t;

   exp_t       sb_q[$];
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] model_acc = 8'h00;

   alu_seq_core #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .use_acc   (use_acc),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .result_hi (result_hi),
      .flags     (flags)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
      exp_t e;
      int   s;
      int   sx;
      int   sy;
      int   sh;
      logic c;
      logic v;
      sx = x; if (x[7]) sx = sx - 256;
      sy = y; if (y[7]) sy = sy - 256;
      sh = y % 8;
      c = 1'b0; v = 1'b0;
      e.hi = 8'h00;
      e.res = 8'h00;
      case (o)
         3'd0: begin s = x + y; e.res = s[7:0]; c = (s > 255); v = (sx + sy > 127) || (sx + sy < -128); end
         3'd1: begin s = x - y; e.res = s[7:0]; c = (x < y);   v = (sx - sy > 127) || (sx - sy < -128); end
         3'd2: e.res = x & y;
         3'd3: e.res = x | y;
         3'd4: e.res = x ^ y;
         3'd5: begin s = x << sh; e.res = s[7:0]; c = (sh != 0) && (((x >> (8 - sh)) & 8'h01) != 0); end
         3'd6: begin e.res = x >> sh; c = (sh != 0) && (((x >> (sh - 1)) & 8'h01) != 0); end
         default: begin s = x * y; e.res = s[7:0]; e.hi = s[15:8]; c = (e.hi != 0); v = c; end
      endcase
      e.flg = {e.res[7], (e.res == 8'h00), c, v};
      e.lat = (o == 3'd7) ? 9 : 1;
      return e;
   endfunction

   task automatic do_op(input logic [2:0] o, input logic ua, input logic [7:0] x, input logic [7:0] y,
                        input int hold, input bit junk);
      exp_t e;
      int   lat;
      int   w;
      bit   rdy_leak;
      e = model(o, ua ? model_acc : x, y);
      sb_q.push_back(e);
      model_acc = e.res;
      w = 0;
      while (!in_ready && w < 20) begin
         @(posedge clk); #1; w++;
      end
      in_valid = 1'b1; op = o; use_acc = ua; b = y;
      a = ua ? 8'($urandom) : x;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      rdy_leak = 1'b0;
      while (!out_valid && lat < 60) begin
         if (in_ready) rdy_leak = 1'b1;
         if (junk) begin
            in_valid = 1'b1; op = 3'($urandom); use_acc = 1'b0;
            a = 8'($urandom); b = 8'($urandom); out_ready = 1'b1;
         end
         @(posedge clk); #1; lat++;
      end
      in_valid = 1'b0;
      chk("latency", lat, e.lat);
      if (junk) chk("busy_in_ready", rdy_leak, 0);
      for (int i = 0; i < hold; i++) begin
         chk("hold_result", result, e.res);
         chk("hold_flags", flags, e.flg);
         chk("hold_in_ready", in_ready, 0);
         chk("hold_out_valid", out_valid, 1);
         @(posedge clk); #1;
      end
      e = sb_q.pop_front();
      chk("out_valid", out_valid, 1);
      chk("result", result, e.res);
      chk("result_hi", result_hi, e.hi);
      chk("flags", flags, e.flg);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("ov_after_hs", out_valid, 0);
      chk("ir_after_hs", in_ready, 1);
   endtask

   initial begin
      #1;
      chk("rst_result", result, 0);
      chk("rst_result_hi", result_hi, 0);
      chk("rst_flags", flags, 0);
      chk("rst_out_valid", out_valid, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_in_ready", in_ready, 1);

      do_op(3'd0, 1'b0, 8'hF0, 8'h20, 0, 1'b0);
      do_op(3'd1, 1'b0, 8'h80, 8'h01, 0, 1'b0);
      do_op(3'd1, 1'b0, 8'h01, 8'h02, 0, 1'b0);
      do_op(3'd7, 1'b0, 8'hFF, 8'hFF, 0, 1'b1);
      do_op(3'd0, 1'b0, 8'h05, 8'h03, 0, 1'b0);
      do_op(3'd0, 1'b1, 8'h55, 8'h02, 0, 1'b0);
      do_op(3'd5, 1'b1, 8'h00, 8'h01, 0, 1'b0);
      do_op(3'd5, 1'b0, 8'h81, 8'h01, 0, 1'b0);
      do_op(3'd4, 1'b0, 8'h3C, 8'h3C, 3, 1'b0);
      do_op(3'd6, 1'b0, 8'h81, 8'h00, 0, 1'b0);

      // reset during cycle 4 of a multiply discards it and clears acc
      in_valid = 1'b1; op = 3'd7; use_acc = 1'b0; a = 8'hAB; b = 8'hCD;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("mrst_result", result, 0);
      chk("mrst_result_hi", result_hi, 0);
      chk("mrst_flags", flags, 0);
      chk("mrst_out_valid", out_valid, 0);
      @(posedge clk); #1 rst = 1'b0;
      model_acc = 8'h00;
      chk("mrst_in_ready", in_ready, 1);
      repeat (12) @(posedge clk);
      #1 chk("mrst_no_result", out_valid, 0);
      do_op(3'd0, 1'b1, 8'h55, 8'h07, 0, 1'b0);

      for (int k = 0; k < 12; k++) begin
         do_op(3'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)), 1'b0);
      end
      do_op(3'd7, 1'b1, 8'h00, 8'h13, 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
